// File: rtl/soc_bus_fabric.sv
// soc_bus_fabric: address decoder, read-data mux, wait-state generator and IRQ
// aggregator sitting between the 65xx CPU core and RAM, ROM and NSLOT I/O slots.
//
// Build option: define BUS_WAIT_EN to implement the per-slot wait-state FSM
// (SLOT_WAIT). When undefined, cpu_rdy is tied high and SLOT_WAIT is ignored.
//
// Ports:
//   CLK1, reset_n          system clock, asynchronous active-low reset
//   cpu_ab/we_n/do/di      CPU address, write strobe (low = write), write/read data
//   cpu_rdy, cpu_irq_n     CPU ready, aggregated active-low IRQ (registered)
//   ext_irq_n              external unmaskable IRQ, active-low
//   ram_cs_n/ram_do        RAM select and read data
//   rom_do                 ROM read data
//   slot_cs_n/do/irq_n     per-slot select, read data (8 bits each), IRQ
//   pclk                   one-cycle peripheral clock-enable pulse every PCLK_DIV cycles
module soc_bus_fabric #(
  parameter int unsigned             NSLOT     = 4,
  parameter logic [3:0]              RAMPAGE   = 4'h0,
  parameter logic [3:0]              IOPAGE    = 4'hD,
  parameter int unsigned             WAIT_W    = 3,
  parameter logic [NSLOT*WAIT_W-1:0] SLOT_WAIT = '0,
  parameter int unsigned             PCLK_DIV  = 10
) (
  input  logic               CLK1,
  input  logic               reset_n,
  input  logic [15:0]        cpu_ab,
  input  logic               cpu_we_n,
  input  logic [7:0]         cpu_do,
  output logic [7:0]         cpu_di,
  output logic               cpu_rdy,
  output logic               cpu_irq_n,
  input  logic               ext_irq_n,
  output logic               ram_cs_n,
  input  logic [7:0]         ram_do,
  input  logic [7:0]         rom_do,
  output logic [NSLOT-1:0]   slot_cs_n,
  input  logic [8*NSLOT-1:0] slot_do,
  input  logic [NSLOT-1:0]   slot_irq_n,
  output logic               pclk
);

  typedef enum logic [2:0] {SrcRom, SrcRam, SrcSlot, SrcCtl, SrcUnmap} src_e;

  localparam logic [5:0]       CtlSub   = 6'h3F;
  localparam logic [5:0]       NSlotSub = 6'(NSLOT);
  localparam int unsigned      PcntW    = $clog2(PCLK_DIV);
  localparam logic [PcntW-1:0] PcntMax  = PcntW'(PCLK_DIV - 1);

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  logic [3:0] w_page;
  logic [5:0] w_sub;
  logic       w_is_ram, w_is_io, w_is_slot, w_is_ctl;
  src_e       w_src;
  logic       w_rdy;

  assign w_page    = cpu_ab[15:12];
  assign w_sub     = cpu_ab[11:6];
  assign w_is_ram  = (w_page == RAMPAGE);
  assign w_is_io   = !w_is_ram && (w_page == IOPAGE);
  assign w_is_slot = w_is_io && (w_sub < NSlotSub);
  assign w_is_ctl  = w_is_io && (w_sub == CtlSub);

  always_comb begin
    w_src = SrcRom;
    if (w_is_ram)       w_src = SrcRam;
    else if (w_is_slot) w_src = SrcSlot;
    else if (w_is_ctl)  w_src = SrcCtl;
    else if (w_is_io)   w_src = SrcUnmap;
  end

  assign ram_cs_n = ~w_is_ram;

  always_comb begin
    slot_cs_n = '1;
    for (int unsigned k = 0; k < NSLOT; k++) begin
      if (w_is_io && (w_sub == 6'(k))) slot_cs_n[k] = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Wait-state FSM
  // ---------------------------------------------------------------------------
`ifdef BUS_WAIT_EN
  typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

  localparam logic [WAIT_W-1:0] WaitOne = WAIT_W'(1);
  localparam logic [WAIT_W-1:0] WaitTwo = WAIT_W'(2);

  state_e            r_state;
  logic [WAIT_W-1:0] r_cnt;
  logic [WAIT_W-1:0] w_n;
  logic              w_wait_req;

  always_comb begin
    w_n = '0;
    for (int unsigned k = 0; k < NSLOT; k++) begin
      if (w_sub == 6'(k)) w_n = SLOT_WAIT[k*WAIT_W +: WAIT_W];
    end
  end

  assign w_wait_req = w_is_slot && (w_n != '0);

  // The IDLE cycle of a waited access already counts as the first wait cycle,
  // so WAIT is entered with n-2 remaining.
  always_ff @(posedge CLK1 or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= StIdle;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        StIdle: begin
          if (w_wait_req) begin
            if (w_n == WaitOne) begin
              r_state <= StDone;
            end else begin
              r_state <= StWait;
              r_cnt   <= w_n - WaitTwo;
            end
          end
        end
        StWait: begin
          if (r_cnt == '0) r_state <= StDone;
          else             r_cnt   <= r_cnt - WaitOne;
        end
        StDone:  r_state <= StIdle;
        default: r_state <= StIdle;
      endcase
    end
  end

  // Forced high while in reset so an interrupted wait releases the CPU at once,
  // even if the waited address is still on the bus.
  always_comb begin
    w_rdy = 1'b1;
    if (reset_n) begin
      case (r_state)
        StIdle:  w_rdy = ~w_wait_req;
        StWait:  w_rdy = 1'b0;
        default: w_rdy = 1'b1;
      endcase
    end
  end
`else
  assign w_rdy = 1'b1;
`endif

  assign cpu_rdy = w_rdy;

  // ---------------------------------------------------------------------------
  // Registered read select, CTL registers, IRQ path
  // ---------------------------------------------------------------------------
  src_e             r_src;
  logic [2:0]       r_idx;
  logic             r_a0;
  logic [NSLOT-1:0] r_mask;
  logic [NSLOT-1:0] r_irq_sync;
  logic             r_irq_n;
  logic [PcntW-1:0] r_pcnt;

  // Select only advances when the CPU completes the cycle, so waited reads
  // pick up slot data after the DONE edge.
  always_ff @(posedge CLK1 or negedge reset_n) begin
    if (!reset_n) begin
      r_src <= SrcRom;
      r_idx <= '0;
      r_a0  <= 1'b0;
    end else if (w_rdy) begin
      r_src <= w_src;
      r_idx <= w_sub[2:0];
      r_a0  <= cpu_ab[0];
    end
  end

  always_ff @(posedge CLK1 or negedge reset_n) begin
    if (!reset_n) begin
      r_mask <= '1;
    end else if (w_is_ctl && cpu_ab[0] && !cpu_we_n && w_rdy) begin
      r_mask <= cpu_do[NSLOT-1:0];
    end
  end

  always_ff @(posedge CLK1 or negedge reset_n) begin
    if (!reset_n) begin
      r_irq_sync <= '0;
      r_irq_n    <= 1'b1;
    end else begin
      r_irq_sync <= ~slot_irq_n;
      r_irq_n    <= ext_irq_n & ~|(r_irq_sync & r_mask);
    end
  end

  assign cpu_irq_n = r_irq_n;

  always_ff @(posedge CLK1 or negedge reset_n) begin
    if (!reset_n)               r_pcnt <= '0;
    else if (r_pcnt == PcntMax) r_pcnt <= '0;
    else                        r_pcnt <= r_pcnt + PcntW'(1);
  end

  assign pclk = (r_pcnt == PcntMax);

  always_comb begin
    cpu_di = 8'hFF;
    case (r_src)
      SrcRam: cpu_di = ram_do;
      SrcRom: cpu_di = rom_do;
      SrcSlot: begin
        for (int unsigned k = 0; k < NSLOT; k++) begin
          if (r_idx == 3'(k)) cpu_di = slot_do[8*k +: 8];
        end
      end
      SrcCtl:  cpu_di = r_a0 ? 8'(r_mask) : 8'(r_irq_sync);
      default: cpu_di = 8'hFF;
    endcase
  end

  // Address bits inside a slot subpage and upper write-data bits are not decoded here.
  logic w_unused;
  assign w_unused = ^{cpu_ab[5:1], cpu_do};

endmodule

// File: tb/tb_soc_bus_fabric.sv
// Testbench for soc_bus_fabric (NSLOT=4, PCLK_DIV=10, slot wait fields 0/1/3/2).
// Adapts its wait-state expectations to whether BUS_WAIT_EN is defined.
module tb_soc_bus_fabric;

`ifdef BUS_WAIT_EN
  localparam bit WaitEn = 1'b1;
`else
  localparam bit WaitEn = 1'b0;
`endif

  localparam int          MaxWait  = 20;
  localparam logic [11:0] SlotWait = {3'd2, 3'd3, 3'd1, 3'd0};
  int slot_wait_cycles [4] = '{0, 1, 3, 2};

  logic        CLK1, reset_n;
  logic [15:0] cpu_ab;
  logic        cpu_we_n;
  logic [7:0]  cpu_do, cpu_di;
  logic        cpu_rdy, cpu_irq_n, ext_irq_n, ram_cs_n, pclk;
  logic [7:0]  ram_do, rom_do;
  logic [3:0]  slot_cs_n, slot_irq_n;
  logic [31:0] slot_do;

  int checks = 0;
  int errors = 0;
  logic [3:0] m_mask = 4'hF;
  logic [7:0] slot_reg = 8'h00;

  soc_bus_fabric #(
    .NSLOT(4), .RAMPAGE(4'h0), .IOPAGE(4'hD), .WAIT_W(3), .SLOT_WAIT(SlotWait), .PCLK_DIV(10)
  ) dut (
    .CLK1(CLK1), .reset_n(reset_n), .cpu_ab(cpu_ab), .cpu_we_n(cpu_we_n), .cpu_do(cpu_do),
    .cpu_di(cpu_di), .cpu_rdy(cpu_rdy), .cpu_irq_n(cpu_irq_n), .ext_irq_n(ext_irq_n),
    .ram_cs_n(ram_cs_n), .ram_do(ram_do), .rom_do(rom_do), .slot_cs_n(slot_cs_n),
    .slot_do(slot_do), .slot_irq_n(slot_irq_n), .pclk(pclk)
  );

  initial begin
    CLK1 = 1'b0;
    forever #5 CLK1 = ~CLK1;
  end

  // Behaviour of a peripheral in slot 2: it latches a write when the CPU completes the cycle.
  always @(posedge CLK1) begin
    if (reset_n && !slot_cs_n[2] && !cpu_we_n && cpu_rdy) slot_reg <= cpu_do;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Runs one CPU bus cycle starting just after an edge; returns how many cycles
  // cpu_rdy stayed low, the selects seen, and whether they moved during the wait.
  task automatic run_access(input logic [15:0] a, input bit wr, input logic [7:0] wd,
                            output int waits, output logic rcs, output logic [3:0] scs,
                            output bit moved);
    cpu_ab = a; cpu_we_n = ~wr; cpu_do = wd;
    #1;
    rcs = ram_cs_n; scs = slot_cs_n; moved = 1'b0; waits = 0;
    while (cpu_rdy !== 1'b1 && waits < MaxWait) begin
      @(posedge CLK1); #1;
      waits++;
      if (ram_cs_n !== rcs || slot_cs_n !== scs) moved = 1'b1;
    end
    @(posedge CLK1); #1;
  endtask

  task automatic bus_idle;
    cpu_ab = 16'hF000; cpu_we_n = 1'b1; cpu_do = 8'h00;
  endtask

  task automatic test_reset;
    reset_n = 1'b0; bus_idle(); rom_do = 8'h3E; ram_do = 8'h00; slot_do = '0;
    slot_irq_n = 4'hF; ext_irq_n = 1'b1;
    repeat (3) @(posedge CLK1);
    #1;
    checks++; if (cpu_rdy !== 1'b1) begin errors++; $display("FAIL reset_rdy: got %b want 1", cpu_rdy); end
    checks++; if (cpu_irq_n !== 1'b1) begin errors++; $display("FAIL reset_irq: got %b want 1", cpu_irq_n); end
    checks++; if (pclk !== 1'b0) begin errors++; $display("FAIL reset_pclk: got %b want 0", pclk); end
    checks++; if (cpu_di !== 8'h3E) begin errors++; $display("FAIL reset_di: got %h want 3e", cpu_di); end
    checks++; if (slot_cs_n !== 4'hF) begin errors++; $display("FAIL reset_scs: got %b want 1111", slot_cs_n); end
    reset_n = 1'b1;
    m_mask = 4'hF;
    // pclk is high while the counter holds 9, i.e. it is sampled by edges 10, 20, 30.
    for (int e = 1; e <= 35; e++) begin
      @(posedge CLK1); #1;
      checks++;
      if (pclk !== ((e % 10) == 9)) begin
        errors++; $display("FAIL pclk_edge%0d: got %b want %b", e, pclk, (e % 10) == 9);
      end
    end
  endtask

  task automatic test_ram_rom;
    cpu_ab = 16'h0123; cpu_we_n = 1'b1; ram_do = 8'h5A; rom_do = 8'h00; #1;
    checks++; if (ram_cs_n !== 1'b0) begin errors++; $display("FAIL ram_cs: got %b want 0", ram_cs_n); end
    @(posedge CLK1); #1;
    cpu_ab = 16'hF000; rom_do = 8'hC3; #1;
    checks++; if (cpu_di !== 8'h5A) begin errors++; $display("FAIL ram_di: got %h want 5a", cpu_di); end
    checks++; if (ram_cs_n !== 1'b1) begin errors++; $display("FAIL rom_ramcs: got %b want 1", ram_cs_n); end
    @(posedge CLK1); #1;
    checks++; if (cpu_di !== 8'hC3) begin errors++; $display("FAIL rom_di: got %h want c3", cpu_di); end
  endtask

  task automatic test_wait_slot;
    int w; logic rc; logic [3:0] sc; bit mv;
    slot_do = {8'h11, 8'h77, 8'h22, 8'h33};
    run_access(16'hD080, 1'b0, 8'h00, w, rc, sc, mv);
    checks++; if (sc !== 4'b1011) begin errors++; $display("FAIL wait_scs: got %b want 1011", sc); end
    checks++; if (w !== (WaitEn ? 3 : 0)) begin errors++; $display("FAIL wait_cycles: got %0d want %0d", w, WaitEn ? 3 : 0); end
    checks++; if (mv !== 1'b0) begin errors++; $display("FAIL wait_cs_hold: got %b want 0", mv); end
    checks++; if (cpu_di !== 8'h77) begin errors++; $display("FAIL wait_di: got %h want 77", cpu_di); end
    bus_idle();
  endtask

  task automatic test_unmapped;
    int w; logic rc; logic [3:0] sc; bit mv;
    slot_do = 32'($urandom); rom_do = 8'($urandom); ram_do = 8'($urandom);
    run_access(16'hD140, 1'b0, 8'h00, w, rc, sc, mv);
    checks++; if (sc !== 4'hF || rc !== 1'b1) begin errors++; $display("FAIL unmap_cs: got %b/%b want 1111/1", sc, rc); end
    checks++; if (cpu_di !== 8'hFF) begin errors++; $display("FAIL unmap_di: got %h want ff", cpu_di); end
    bus_idle();
  endtask

  task automatic test_irq;
    int w; logic rc; logic [3:0] sc; bit mv;
    run_access(16'hDFC1, 1'b1, 8'h0F, w, rc, sc, mv);
    bus_idle(); m_mask = 4'hF;
    @(posedge CLK1); #1;
    slot_irq_n = 4'b1101;
    @(posedge CLK1); #1;
    checks++; if (cpu_irq_n !== 1'b1) begin errors++; $display("FAIL irq_lat1: got %b want 1", cpu_irq_n); end
    @(posedge CLK1); #1;
    checks++; if (cpu_irq_n !== 1'b0) begin errors++; $display("FAIL irq_lat2: got %b want 0", cpu_irq_n); end
    run_access(16'hDFC0, 1'b0, 8'h00, w, rc, sc, mv);
    checks++; if (cpu_di !== 8'h02) begin errors++; $display("FAIL irq_status: got %h want 02", cpu_di); end
    cpu_ab = 16'hDFC1; cpu_we_n = 1'b0; cpu_do = 8'h00;
    @(posedge CLK1); #1;
    bus_idle(); m_mask = 4'h0;
    checks++; if (cpu_irq_n !== 1'b0) begin errors++; $display("FAIL mask_lat0: got %b want 0", cpu_irq_n); end
    @(posedge CLK1); #1;
    checks++; if (cpu_irq_n !== 1'b1) begin errors++; $display("FAIL mask_lat1: got %b want 1", cpu_irq_n); end
    run_access(16'hDFC1, 1'b0, 8'h00, w, rc, sc, mv);
    checks++; if (cpu_di !== 8'h00) begin errors++; $display("FAIL mask_read: got %h want 00", cpu_di); end
    bus_idle();
    ext_irq_n = 1'b0;
    @(posedge CLK1); #1;
    checks++; if (cpu_irq_n !== 1'b0) begin errors++; $display("FAIL ext_irq: got %b want 0", cpu_irq_n); end
    ext_irq_n = 1'b1; slot_irq_n = 4'hF;
    @(posedge CLK1); #1;
    checks++; if (cpu_irq_n !== 1'b1) begin errors++; $display("FAIL irq_clear: got %b want 1", cpu_irq_n); end
  endtask

  task automatic test_irq_random;
    int w; logic rc; logic [3:0] sc; bit mv;
    logic [7:0] mv8; logic [3:0] s_prev, s_new; logic e_new, exp;
    for (int m = 0; m < 4; m++) begin
      mv8 = 8'($urandom);
      run_access(16'hDFC1, 1'b1, mv8, w, rc, sc, mv);
      bus_idle(); m_mask = mv8[3:0];
      s_prev = slot_irq_n;
      for (int c = 0; c < 20; c++) begin
        s_new = 4'($urandom); e_new = ($urandom_range(0, 3) != 0);
        slot_irq_n = s_new; ext_irq_n = e_new;
        @(posedge CLK1); #1;
        // Slot IRQs take one extra edge through the synchroniser; ext_irq_n does not.
        exp = e_new & ~|(~s_prev & m_mask);
        checks++;
        if (cpu_irq_n !== exp) begin
          errors++; $display("FAIL irq_rand m%0d c%0d: got %b want %b", m, c, cpu_irq_n, exp);
        end
        s_prev = s_new;
      end
    end
    slot_irq_n = 4'hF; ext_irq_n = 1'b1;
  endtask

  task automatic test_random_access;
    int w, page, sub, p, exp_w; logic rc, exp_rc; logic [3:0] sc, exp_sc; bit mv, wr;
    logic [15:0] a; logic [7:0] wd, exp_di;
    for (int i = 0; i < 150; i++) begin
      case ($urandom_range(0, 5))
        0: a = {4'h0, 12'($urandom)};
        1: begin
          do p = $urandom_range(0, 15); while (p == 0 || p == 13);
          a = {4'(p), 12'($urandom)};
        end
        2: a = {4'hD, 6'($urandom_range(0, 3)), 6'($urandom)};
        3: a = {4'hD, 6'($urandom_range(4, 62)), 6'($urandom)};
        4: a = {4'hD, 6'h3F, 6'($urandom)};
        default: a = 16'($urandom);
      endcase
      wr = ($urandom_range(0, 3) == 0); wd = 8'($urandom);
      ram_do = 8'($urandom); rom_do = 8'($urandom); slot_do = 32'($urandom);
      slot_irq_n = 4'($urandom);
      page = int'(a[15:12]); sub = int'(a[11:6]);
      exp_rc = (page != 0);
      exp_sc = 4'hF;
      if (page == 13 && sub < 4) exp_sc[sub] = 1'b0;
      exp_w = (WaitEn && page == 13 && sub < 4) ? slot_wait_cycles[sub] : 0;
      if (page == 0) exp_di = ram_do;
      else if (page != 13) exp_di = rom_do;
      else if (sub < 4) exp_di = slot_do[8*sub +: 8];
      else if (sub == 63) exp_di = a[0] ? {4'h0, m_mask} : {4'h0, ~slot_irq_n};
      else exp_di = 8'hFF;
      run_access(a, wr, wd, w, rc, sc, mv);
      checks++; if (rc !== exp_rc) begin errors++; $display("FAIL rnd%0d ram_cs a=%h: got %b want %b", i, a, rc, exp_rc); end
      checks++; if (sc !== exp_sc) begin errors++; $display("FAIL rnd%0d slot_cs a=%h: got %b want %b", i, a, sc, exp_sc); end
      checks++; if (w !== exp_w) begin errors++; $display("FAIL rnd%0d waits a=%h: got %0d want %0d", i, a, w, exp_w); end
      checks++; if (mv !== 1'b0) begin errors++; $display("FAIL rnd%0d cs_hold a=%h: got %b want 0", i, a, mv); end
      if (!wr) begin
        checks++;
        if (cpu_di !== exp_di) begin errors++; $display("FAIL rnd%0d di a=%h: got %h want %h", i, a, cpu_di, exp_di); end
      end
      if (wr && page == 13 && sub == 63 && a[0]) m_mask = wd[3:0];
    end
    bus_idle();
    slot_irq_n = 4'hF;
  endtask

  task automatic test_back_to_back;
    int w, s; logic rc; logic [3:0] sc; bit mv;
    logic [15:0] seq [6] = '{16'hD080, 16'hD0BF, 16'hD040, 16'hD07F, 16'hD0C0, 16'hD080};
    for (int i = 0; i < 6; i++) begin
      s = int'(seq[i][11:6]);
      slot_do = 32'($urandom);
      run_access(seq[i], 1'b0, 8'h00, w, rc, sc, mv);
      checks++;
      if (w !== (WaitEn ? slot_wait_cycles[s] : 0)) begin
        errors++; $display("FAIL b2b%0d waits: got %0d want %0d", i, w, WaitEn ? slot_wait_cycles[s] : 0);
      end
      checks++;
      if (cpu_di !== slot_do[8*s +: 8]) begin
        errors++; $display("FAIL b2b%0d di: got %h want %h", i, cpu_di, slot_do[8*s +: 8]);
      end
    end
    bus_idle();
  endtask

  task automatic test_reset_mid_wait;
    int w; logic rc; logic [3:0] sc; bit mv;
    run_access(16'hD080, 1'b1, 8'hA5, w, rc, sc, mv);
    bus_idle();
    checks++; if (slot_reg !== 8'hA5) begin errors++; $display("FAIL rmw_commit: got %h want a5", slot_reg); end
    cpu_ab = 16'hD084; cpu_we_n = 1'b0; cpu_do = 8'h3C;
    @(posedge CLK1); #1;
    checks++; if (cpu_rdy !== !WaitEn) begin errors++; $display("FAIL rmw_wait2: got %b want %b", cpu_rdy, !WaitEn); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if (cpu_rdy !== 1'b1) begin errors++; $display("FAIL rmw_rdy: got %b want 1", cpu_rdy); end
    @(posedge CLK1); #1;
    checks++;
    if (slot_reg !== (WaitEn ? 8'hA5 : 8'h3C)) begin
      errors++; $display("FAIL rmw_nocommit: got %h want %h", slot_reg, WaitEn ? 8'hA5 : 8'h3C);
    end
    bus_idle();
    reset_n = 1'b1;
    m_mask = 4'hF;
    slot_do = {8'h00, 8'h9C, 8'h00, 8'h00};
    run_access(16'hD080, 1'b0, 8'h00, w, rc, sc, mv);
    checks++; if (w !== (WaitEn ? 3 : 0)) begin errors++; $display("FAIL rmw_idle_waits: got %0d want %0d", w, WaitEn ? 3 : 0); end
    checks++; if (cpu_di !== 8'h9C) begin errors++; $display("FAIL rmw_di: got %h want 9c", cpu_di); end
    bus_idle();
  endtask

  initial begin
    test_reset();
    test_ram_rom();
    test_wait_slot();
    test_unmapped();
    test_irq();
    test_irq_random();
    test_random_access();
    test_back_to_back();
    test_reset_mid_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
